load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-side partner of the instruction decoder: consumes the load/store requests the decoder enables (LB/LH/LW/LBU/LHU, SB/SH/SW) and turns them into word-aligned requests on a data-memory bus.
- Runs a valid/grant/rvalid handshake toward memory.
- Generates byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data to the writeback mux.
- Holds the core via req_ready_o while an access is in flight; flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, byte address width on both core and memory sides.
- DATA_WIDTH, 32, bus width; fixed at 32, other values unsupported.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- req_valid_i  input  1  core presents a load/store this cycle.
- req_write_i  input  1  1 = store (decoder mem_write_enable), 0 = load.
- funct3_i  input  3  width/sign select: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  input  ADDR_WIDTH  byte address (rs1 + imm from ALU).
- store_data_i  input  32  rs2 value.
- req_ready_o  output  1  unit idle and accepting a request.
- resp_valid_o  output  1  one-cycle completion pulse.
- load_data_o  output  32  extended load result; valid when resp_valid_o=1 and the request was a load.
- fault_o  output  1  with resp_valid_o: misaligned or illegal funct3.
- mem_req_o  output  1  memory request valid.
- mem_we_o  output  1  memory write.
- mem_addr_o  output  ADDR_WIDTH  word address, bits [1:0] forced to 0.
- mem_be_o  output  4  byte enables.
- mem_wdata_o  output  32  lane-replicated store data.
- mem_gnt_i  input  1  memory accepted the request this cycle.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  32  read word.

Behaviour:
- Reset (rst_ni=0, async):
  - State goes to IDLE.
  - req_ready_o=1.
  - resp_valid_o, fault_o, mem_req_o and mem_we_o are 0.
  - mem_be_o=0; mem_addr_o, mem_wdata_o and load_data_o are 0.
  - A reset mid-transaction abandons it; a late mem_rvalid_i after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, funct3, write flag and data. Compute be/wdata from addr[1:0].
- Fault check, done at acceptance:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Illegal funct3: 011, 110, 111; also 100/101 on a store.
  - On fault, go to RESP with fault_o=1 and issue no memory request.
  - Otherwise go to REQ.
- REQ:
  - Drive mem_req_o=1 and hold addr/be/we/wdata stable until mem_gnt_i.
  - On gnt with a store, go to RESP.
  - On gnt with a load, go to WAIT.
  - mem_rvalid_i in REQ is ignored.
- WAIT: on mem_rvalid_i, register the extended data and go to RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then IDLE.
  - No backpressure on the response.
  - fault_o and load_data_o are held until the next acceptance.
- Latency, counting acceptance edge N:
  - Store with immediate gnt: resp_valid_o high in cycle N+2.
  - Load with gnt at N+1 and rvalid at N+2: resp_valid_o high at N+3.
  - Each extra stall cycle of gnt or rvalid adds one cycle.
  - Back-to-back throughput: one access per 3 cycles (store) or 4 cycles (load) minimum.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0].
  - W: 4'b1111.
  - Loads drive the same be with mem_we_o=0.
- Store data:
  - SB: byte replicated to all four lanes.
  - SH: halfword replicated to both halves.
  - SW: passed through.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Fault response: load_data_o=0.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt immediate -> mem_addr_o=0x100, be=1111, we=1; resp_valid_o at N+2; fault_o=0.
- SB addr=0x103, data=0x000000A5 -> be=1000, mem_wdata_o=0xA5A5A5A5, mem_addr_o=0x100.
- LB addr=0x102, rdata=0x11807F22, rvalid 3 cycles after gnt -> load_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU 0x102 -> 0x00001180.
- LW addr=0x101 -> fault_o=1 and resp_valid_o at N+1; mem_req_o never asserted. SH funct3=100 -> fault_o=1.
- gnt held low 5 cycles -> mem_req_o, addr, be and wdata stable throughout; req_ready_o=0 until back in IDLE.
- rst_ni pulled low in WAIT, then mem_rvalid_i arrives after release -> resp_valid_o stays 0; req_ready_o=1; state IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns decoded LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned
// valid/grant/rvalid memory transactions and returns extended load data.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  req_ready_o,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  fault_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                  state;
    logic [2:0]              f3_q;
    logic [1:0]              lane_q;
    logic                    write_q;

    logic                    misaligned;
    logic                    illegal;
    logic [3:0]              acc_be;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [7:0]              rbyte;
    logic [15:0]             rhalf;
    logic [DATA_WIDTH-1:0]   rext;

    // Decode of the incoming request: lane enables, replicated store data, fault reasons.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        acc_be     = 4'b0000;
        acc_wdata  = store_data_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                acc_be    = 4'b0001 << addr_i[1:0];
                acc_wdata = {4{store_data_i[7:0]}};
            end
            3'b001, 3'b101: begin
                acc_be     = 4'b0011 << addr_i[1:0];
                acc_wdata  = {2{store_data_i[15:0]}};
                misaligned = addr_i[0];
            end
            3'b010: begin
                acc_be     = 4'b1111;
                misaligned = (addr_i[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        if (req_write_i && funct3_i[2]) begin
            illegal = 1'b1;
        end
    end

    // Lane extraction of the returned word, using the address latched at acceptance.
    always_comb begin
        rbyte = mem_rdata_i[{lane_q, 3'b000} +: 8];
        rhalf = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  rext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rext = {24'h000000, rbyte};
            3'b001:  rext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rext = {16'h0000, rhalf};
            default: rext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            write_q      <= 1'b0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            load_data_o  <= '0;
            fault_o      <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= 4'b0000;
            mem_wdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        f3_q        <= funct3_i;
                        lane_q      <= addr_i[1:0];
                        write_q     <= req_write_i;
                        req_ready_o <= 1'b0;
                        fault_o     <= misaligned | illegal;
                        load_data_o <= '0;
                        if (misaligned || illegal) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                        end else begin
                            state       <= REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_write_i;
                            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_o    <= acc_be;
                            mem_wdata_o <= acc_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (write_q) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        load_data_o  <= rext;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
